// File: rtl/product_accumulator.sv
// product_accumulator: sums blocks of signed products into a guard-extended accumulator and presents each block sum on a valid/ready port.
// Build option: define ACC_SAT_EN to clamp the running sum on signed overflow instead of wrapping.
module product_accumulator #(
  parameter int PROD_W  = 64,
  parameter int GUARD_W = 8,
  parameter int LEN_W   = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic [LEN_W-1:0]          i_block_len,
  input  logic                      i_prod_valid,
  input  logic [PROD_W-1:0]         i_prod,
  output logic                      o_prod_ready,
  output logic                      o_acc_valid,
  output logic [PROD_W+GUARD_W-1:0] o_acc,
  output logic                      o_overflow,
  input  logic                      i_acc_ready
);

  localparam int ACC_W = PROD_W + GUARD_W;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_raw;
  logic [ACC_W-1:0]   sum_sel;
  logic               add_ovf;
  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W:0]     count_inc;
  logic               last_accept;
  logic               accept;

  assign prod_ext = {{GUARD_W{i_prod[PROD_W-1]}}, i_prod};
  assign sum_raw  = acc_q + prod_ext;
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Overflow direction follows the common sign of the two addends.
  assign sum_sel = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign sum_sel = sum_raw;
`endif

  // The first product of a block is checked against the live length, later ones against len_q.
  assign eff_len     = (count_q == '0) ?
                       ((i_block_len == '0) ? LEN_W'(1) : i_block_len) : len_q;
  assign count_inc   = {1'b0, count_q} + (LEN_W+1)'(1);
  assign last_accept = (count_inc == {1'b0, eff_len});
  assign accept      = i_prod_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_ovf_d = out_ovf_q;
    if (i_clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_d   = sum_sel;
            count_d = count_inc[LEN_W-1:0];
            ovf_d   = ovf_q | add_ovf;
            if (count_q == '0) begin
              len_d = eff_len;
            end
            if (last_accept) begin
              out_acc_d = sum_sel;
              out_ovf_d = ovf_q | add_ovf;
              state_d   = ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (i_acc_ready) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      count_q   <= '0;
      len_q     <= LEN_W'(1);
      ovf_q     <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      out_acc_q <= out_acc_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign o_prod_ready = (state_q == ST_ACCUM);
  assign o_acc_valid  = (state_q == ST_EMIT);
  assign o_acc        = out_acc_q;
  assign o_overflow   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: vector table, hand-written corner sequences, random blocks vs exact-sum model.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, prod_valid, acc_ready;
  logic        prod_ready, acc_valid, overflow;
  logic [7:0]  block_len;
  logic [63:0] prod;
  logic [71:0] acc;

  logic        clear65, prod_valid65, acc_ready65;
  logic        prod_ready65, acc_valid65, overflow65;
  logic [7:0]  block_len65;
  logic [63:0] prod65;
  logic [64:0] acc65;

  int n_checks = 0;
  int n_fail   = 0;

  product_accumulator dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_block_len(block_len),
    .i_prod_valid(prod_valid), .i_prod(prod), .o_prod_ready(prod_ready),
    .o_acc_valid(acc_valid), .o_acc(acc), .o_overflow(overflow), .i_acc_ready(acc_ready)
  );

  product_accumulator #(.GUARD_W(1)) dut65 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear65), .i_block_len(block_len65),
    .i_prod_valid(prod_valid65), .i_prod(prod65), .o_prod_ready(prod_ready65),
    .o_acc_valid(acc_valid65), .o_acc(acc65), .o_overflow(overflow65), .i_acc_ready(acc_ready65)
  );

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       n;
    logic [3:0][63:0] prods;
    logic [71:0]      exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until it is taken (bounded).
  task automatic send_prod(input logic [63:0] p, input logic [7:0] len);
    bit done = 0;
    bit rdy;
    prod_valid = 1'b1;
    prod       = p;
    block_len  = len;
    for (int t = 0; t < 64 && !done; t++) begin
      rdy = prod_ready;
      step();
      if (rdy) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
    end
  endtask

  logic [127:0]        exact;
  logic signed [127:0] lim_hi, lim_lo;
  logic                exp_ovf_r;
  logic [63:0]         p;
  logic [7:0]          lenf;
  int                  eff;
  logic [64:0]         exp65;

  initial begin
    rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; acc_ready = 1'b1;
    block_len = 8'd0; prod = 64'd0;
    clear65 = 1'b0; prod_valid65 = 1'b0; acc_ready65 = 1'b0;
    block_len65 = 8'd0; prod65 = 64'd0;
    lim_hi = (128'sd1 <<< 71) - 128'sd1;
    lim_lo = -(128'sd1 <<< 71);

    // Reset state
    step(); step();
    check("rst_acc", acc, 0);
    check("rst_valid", acc_valid, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk) rst = 1'b0;
    step();
    check("rst_ready", prod_ready, 1);
    check("rst_ready65", prod_ready65, 1);

    // Table: straight blocks with the sink always ready
    vecs[0].len = 8'd4; vecs[0].n = 3'd4;
    vecs[0].prods = {64'd4, 64'd3, 64'd2, 64'd1};
    vecs[0].exp_acc = 72'd10; vecs[0].exp_ovf = 1'b0;
    vecs[1].len = 8'd2; vecs[1].n = 3'd2;
    vecs[1].prods = {64'd0, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[1].exp_acc = 72'hFF_FFFF_FFFF_FFFF_FFFE; vecs[1].exp_ovf = 1'b0;
    vecs[2].len = 8'd0; vecs[2].n = 3'd1;
    vecs[2].prods = {64'd0, 64'd0, 64'd0, 64'd7};
    vecs[2].exp_acc = 72'd7; vecs[2].exp_ovf = 1'b0;
    vecs[3].len = 8'd3; vecs[3].n = 3'd3;
    vecs[3].prods = {64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vecs[3].exp_acc = 72'hFE_8000_0000_0000_0000; vecs[3].exp_ovf = 1'b0;

    acc_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        if (k == int'(vecs[v].n) - 1) check("vec_pre_last_valid", acc_valid, 0);
        // Later products carry a bogus length that must be ignored.
        send_prod(vecs[v].prods[k], (k == 0) ? vecs[v].len : 8'd1);
      end
      prod_valid = 1'b0;
      check("vec_valid", acc_valid, 1);
      check("vec_acc", acc, vecs[v].exp_acc);
      check("vec_ovf", overflow, vecs[v].exp_ovf);
      check("vec_ready_in_emit", prod_ready, 0);
      step();
      check("vec_valid_after_hs", acc_valid, 0);
      check("vec_ready_after_hs", prod_ready, 1);
      $display("vector %0d: len=%0d acc=%0h", v, vecs[v].len, acc);
    end

    // Stalled sink with a pending product
    acc_ready = 1'b0;
    send_prod(64'd7, 8'd0);
    check("stall_valid", acc_valid, 1);
    check("stall_acc", acc, 7);
    prod_valid = 1'b1; prod = 64'd11; block_len = 8'd1;
    for (int c = 0; c < 5; c++) begin
      check("stall_hold_valid", acc_valid, 1);
      check("stall_hold_acc", acc, 7);
      check("stall_hold_ready", prod_ready, 0);
      step();
    end
    acc_ready = 1'b1;
    step();
    check("stall_bubble_valid", acc_valid, 0);
    check("stall_bubble_ready", prod_ready, 1);
    check("stall_acc_kept", acc, 7);
    acc_ready = 1'b0;
    step();
    prod_valid = 1'b0;
    check("stall_pending_valid", acc_valid, 1);
    check("stall_pending_acc", acc, 11);
    acc_ready = 1'b1;
    step();
    check("stall_done_valid", acc_valid, 0);
    $display("stall sequence done");

    // Clear mid-block, with a product presented in the clear cycle
    send_prod(64'd100, 8'd4);
    send_prod(64'd200, 8'd1);
    prod_valid = 1'b1; prod = 64'd999; clear = 1'b1;
    step();
    clear = 1'b0; prod_valid = 1'b0;
    check("clr_valid", acc_valid, 0);
    for (int k = 0; k < 4; k++) begin
      check("clr_no_early_valid", acc_valid, 0);
      send_prod(64'd1, 8'd4);
    end
    prod_valid = 1'b0;
    check("clr_blk_valid", acc_valid, 1);
    check("clr_blk_acc", acc, 4);
    step();
    $display("clear mid-block done acc=%0h", acc);

    // Clear while presenting a result
    acc_ready = 1'b0;
    send_prod(64'd5, 8'd1);
    prod_valid = 1'b0;
    check("clr_emit_valid_pre", acc_valid, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_emit_valid", acc_valid, 0);
    check("clr_emit_ready", prod_ready, 1);
    send_prod(64'd3, 8'd1);
    prod_valid = 1'b0;
    check("clr_emit_next_acc", acc, 3);
    acc_ready = 1'b1;
    step();
    $display("clear in emit done");

    // Random blocks against an exact-sum model
    for (int b = 0; b < 30; b++) begin
      lenf = 8'($urandom_range(0, 12));
      if (b == 15) lenf = 8'd255;
      eff = (lenf == 8'd0) ? 1 : int'(lenf);
      exact = '0;
      exp_ovf_r = 1'b0;
      acc_ready = 1'b0;
      for (int k = 0; k < eff; k++) begin
        p = {$urandom(), $urandom()};
        if (b == 15) p = 64'h7FFF_FFFF_FFFF_FFFF;
        exact = exact + {{64{p[63]}}, p};
        if ($signed(exact) > lim_hi || $signed(exact) < lim_lo) exp_ovf_r = 1'b1;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          prod_valid = 1'b0;
          step();
        end
        check("rnd_no_early_valid", acc_valid, 0);
        send_prod(p, (k == 0) ? lenf : 8'($urandom()));
      end
      prod_valid = 1'b0;
      check("rnd_valid", acc_valid, 1);
      check("rnd_acc", acc, exact[71:0]);
      check("rnd_ovf", overflow, exp_ovf_r);
      prod_valid = 1'b1; prod = {$urandom(), $urandom()};
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        step();
        check("rnd_stall_acc", acc, exact[71:0]);
        check("rnd_stall_ready", prod_ready, 0);
      end
      acc_ready = 1'b1;
      step();
      prod_valid = 1'b0;
      check("rnd_after_hs", acc_valid, 0);
      $display("random block %0d: len=%0d acc=%0h", b, lenf, exact[71:0]);
    end

    // Narrow-guard instance: overflow on the third add
    prod_valid65 = 1'b1; prod65 = 64'h7FFF_FFFF_FFFF_FFFF; block_len65 = 8'd3; acc_ready65 = 1'b0;
    step(); step();
    check("ovf65_not_yet", acc_valid65, 0);
    step();
    prod_valid65 = 1'b0;
`ifdef ACC_SAT_EN
    exp65 = 65'h0_FFFF_FFFF_FFFF_FFFF;
`else
    exp65 = 65'h1_7FFF_FFFF_FFFF_FFFD;
`endif
    check("ovf65_valid", acc_valid65, 1);
    check("ovf65_acc", acc65, exp65);
    check("ovf65_flag", overflow65, 1);
    $display("overflow block: acc65=%0h ovf=%0d", acc65, overflow65);

    // Asynchronous reset while both instances hold a result
    acc_ready = 1'b0;
    send_prod(64'h1234, 8'd1);
    prod_valid = 1'b0;
    check("arst_pre_acc", acc, 64'h1234);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", acc_valid, 0);
    check("arst_acc", acc, 0);
    check("arst_ovf", overflow, 0);
    check("arst_valid65", acc_valid65, 0);
    check("arst_acc65", acc65, 0);
    check("arst_ovf65", overflow65, 0);
    @(negedge clk) rst = 1'b0;
    step();
    check("arst_ready", prod_ready, 1);
    acc_ready = 1'b1;
    send_prod(64'd9, 8'd1);
    prod_valid = 1'b0;
    check("arst_next_valid", acc_valid, 1);
    check("arst_next_acc", acc, 9);
    step();
    $display("async reset sequence done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
